// File: rtl/wm_btn_pkg.sv
// Shared types and default timing for the washing-machine front-panel arbiter.
// Holds the arbiter state encoding and the one-entry event record.
package wm_btn_pkg;

    localparam int DEF_N_BTN    = 4;
    localparam int DEF_LOCK_CYC = 25_000_000;
    localparam int DEF_LONG_CYC = 50_000_000;

    localparam int EV_ID_W = $clog2(DEF_N_BTN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HELD   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [EV_ID_W-1:0] id;
        logic               is_long;
    } btn_ev_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer plus history register for a vector of raw buttons.
// All flops reset to ones so a button held through reset never yields an edge.
module btn_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] bt,
    output logic [W-1:0] lvl,
    output logic [W-1:0] rise
);

    logic [W-1:0] ff1_q, ff1_d;
    logic [W-1:0] ff2_q, ff2_d;
    logic [W-1:0] prv_q, prv_d;

    always_comb begin
        ff1_d = bt;
        ff2_d = ff1_q;
        prv_d = ff2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= '1;
            ff2_q <= '1;
            prv_q <= '1;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
            prv_q <= prv_d;
        end
    end

    assign lvl  = ff2_q;
    assign rise = ff2_q & ~prv_q;

endmodule

// File: rtl/btn_panel_arbiter.sv
// Front-panel arbiter: one shared lockout/hold timer, fixed-priority press selection,
// and a one-entry valid/ready event buffer toward the control FSM.
module btn_panel_arbiter
    import wm_btn_pkg::*;
#(
    parameter int N_BTN    = DEF_N_BTN,
    parameter int LOCK_CYC = DEF_LOCK_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         bt,
    input  logic                     ev_ready,
    output logic                     ev_valid,
    output logic [$clog2(N_BTN)-1:0] ev_id,
    output logic                     ev_long,
    output logic                     ev_drop,
    output logic                     busy
);

    localparam int ID_W  = $clog2(N_BTN);
    localparam int CNT_W = $clog2(LONG_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] CNT_LONG_HIT = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LOCK_END = CNT_W'(LOCK_CYC - 1);

    // Handshake: the buffered event transfers on any clock edge where ev_valid and
    // ev_ready are both high; ev_id/ev_long hold steady while ev_valid=1, ev_ready=0.

    logic [N_BTN-1:0] lvl;
    logic [N_BTN-1:0] rise;

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ev_valid_q, ev_valid_d;
    btn_ev_t          ev_q, ev_d;
    logic             ev_drop_q, ev_drop_d;

    logic [ID_W-1:0]  pick_id;
    logic             sel_lvl;
    logic             emit;
    btn_ev_t          emit_ev;

    btn_sync #(.W(N_BTN)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .bt   (bt),
        .lvl  (lvl),
        .rise (rise)
    );

    // Lowest set index wins; scanning downward lets the lowest index land last.
    always_comb begin
        pick_id = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (rise[i]) begin
                pick_id = ID_W'(i);
            end
        end
    end

    assign sel_lvl = lvl[sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        emit_ev = '0;

        if (state_q != ST_IDLE && cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (|rise) begin
                    sel_d           = pick_id;
                    emit            = 1'b1;
                    emit_ev.id      = EV_ID_W'(pick_id);
                    emit_ev.is_long = 1'b0;
                    cnt_d           = '0;
                    state_d         = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == CNT_LONG_HIT && sel_lvl) begin
                    emit            = 1'b1;
                    emit_ev.id      = EV_ID_W'(sel_q);
                    emit_ev.is_long = 1'b1;
                    state_d         = ST_HELD;
                end else if (cnt_q >= CNT_LOCK_END && !sel_lvl) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (!sel_lvl) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A full, stalled buffer keeps its contents; the new event is discarded.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_d       = ev_q;
        ev_drop_d  = 1'b0;

        if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end
        if (emit) begin
            if (!ev_valid_q || ev_ready) begin
                ev_valid_d = 1'b1;
                ev_d       = emit_ev;
            end else begin
                ev_drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_q       <= '0;
            ev_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            ev_valid_q <= ev_valid_d;
            ev_q       <= ev_d;
            ev_drop_q  <= ev_drop_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_id    = ID_W'(ev_q.id);
    assign ev_long  = ev_q.is_long;
    assign ev_drop  = ev_drop_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_btn_panel_arbiter.sv
// Self-checking bench for btn_panel_arbiter: directed scenarios with literal
// expectations plus a long randomized run compared cycle-by-cycle to a timing model.
module tb_btn_panel_arbiter;

    localparam int N_BTN    = 4;
    localparam int LOCK_CYC = 8;
    localparam int LONG_CYC = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bt = 4'b0000;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic       ev_long;
    logic       ev_drop;
    logic       busy;

    int checks = 0;
    int errors = 0;

    btn_panel_arbiter #(
        .N_BTN   (N_BTN),
        .LOCK_CYC(LOCK_CYC),
        .LONG_CYC(LONG_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bt      (bt),
        .ev_ready(ev_ready),
        .ev_valid(ev_valid),
        .ev_id   (ev_id),
        .ev_long (ev_long),
        .ev_drop (ev_drop),
        .busy    (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[0] is the newest sample of bt; the arbiter reacts to the sample two
    // edges old, and a press is a sample-two-old high with sample-three-old low.
    logic [3:0] hist[$] = '{4'hF, 4'hF, 4'hF};
    int  m_mode  = 0;     // 0 idle, 1 lockout/hold window, 2 long press held
    int  m_age   = 0;     // cycles since the press was accepted
    int  m_sel   = 0;
    bit  m_valid = 0;
    int  m_id    = 0;
    bit  m_long  = 0;
    bit  m_drop  = 0;
    logic [3:0] m_lvl, m_rise;
    bit  m_emit;
    int  m_eid;
    bit  m_elong;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist    = '{4'hF, 4'hF, 4'hF};
            m_mode  = 0;
            m_age   = 0;
            m_sel   = 0;
            m_valid = 0;
            m_id    = 0;
            m_long  = 0;
            m_drop  = 0;
        end else begin
            m_lvl  = hist[1];
            m_rise = hist[1] & ~hist[2];
            m_emit = 0;
            m_eid  = 0;
            m_elong = 0;
            if (m_mode == 0) begin
                if (m_rise != 0) begin
                    for (int i = 3; i >= 0; i--) if (m_rise[i]) m_sel = i;
                    m_emit = 1; m_eid = m_sel; m_elong = 0;
                    m_mode = 1; m_age = 0;
                end
            end else if (m_mode == 1) begin
                if (m_age == LONG_CYC - 1 && m_lvl[m_sel]) begin
                    m_emit = 1; m_eid = m_sel; m_elong = 1;
                    m_mode = 2;
                end else if (m_age >= LOCK_CYC - 1 && !m_lvl[m_sel]) begin
                    m_mode = 0;
                end
                m_age++;
            end else begin
                if (!m_lvl[m_sel]) m_mode = 0;
            end
            m_drop = m_emit && m_valid && !ev_ready;
            if (m_emit && (!m_valid || ev_ready)) begin
                m_valid = 1; m_id = m_eid; m_long = m_elong;
            end else if (m_valid && ev_ready) begin
                m_valid = 0;
            end
            hist.push_front(bt);
            void'(hist.pop_back());
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ev_valid", int'(ev_valid), int'(m_valid));
            if (m_valid) begin
                chk("ev_id", int'(ev_id), m_id);
                chk("ev_long", int'(ev_long), int'(m_long));
            end
            chk("ev_drop", int'(ev_drop), int'(m_drop));
            chk("busy", int'(busy), int'(m_mode != 0));
        end
    end

    // ---------------- observation counters ----------------
    int cyc = 0;
    int evt_cnt = 0;
    int busy_cnt = 0;
    int drop_cnt = 0;
    logic [2:0] ev_log[$];   // {long, id}
    int ev_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (ev_drop) drop_cnt++;
            if (ev_valid && ev_ready) begin
                evt_cnt++;
                ev_log.push_back({ev_long, ev_id});
                ev_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    int b_evt, b_busy, b_drop, first, first_id, first_long;
    logic [2:0] rec;

    initial begin
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(4);
        chk("reset_ev_valid", int'(ev_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ev_id", int'(ev_id), 0);

        // Single press
        b_evt = evt_cnt; b_busy = busy_cnt;
        ev_ready = 1'b1;
        bt = 4'b0100;
        first = 0; first_id = -1; first_long = -1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (ev_valid && first == 0) begin
                first = n; first_id = ev_id; first_long = ev_long;
            end
        end
        bt = 4'b0000;
        wait_cycles(20);
        chk("single_latency", first, 3);
        chk("single_id", first_id, 2);
        chk("single_long", first_long, 0);
        chk("single_count", evt_cnt - b_evt, 1);
        chk("single_busy_cycles", busy_cnt - b_busy, 8);

        // Bounce on button 1
        b_evt = evt_cnt;
        foreach (rec[i]) ;
        bt = 4'b0010; tick();
        bt = 4'b0000; tick();
        bt = 4'b0010; tick();
        tick();
        bt = 4'b0000; tick();
        bt = 4'b0010; tick();
        bt = 4'b0000;
        wait_cycles(25);
        chk("bounce_count", evt_cnt - b_evt, 1);
        rec = ev_log[b_evt];
        chk("bounce_id", int'(rec[1:0]), 1);

        // Simultaneous press of buttons 1 and 3
        b_evt = evt_cnt;
        bt = 4'b1010;
        wait_cycles(12);
        bt = 4'b0000;
        wait_cycles(25);
        chk("simul_count", evt_cnt - b_evt, 1);
        rec = ev_log[b_evt];
        chk("simul_id", int'(rec[1:0]), 1);

        // Long press on button 0
        b_evt = evt_cnt;
        bt = 4'b0001;
        wait_cycles(30);
        chk("long_held_busy", int'(busy), 1);
        bt = 4'b0000;
        wait_cycles(10);
        chk("long_count", evt_cnt - b_evt, 2);
        chk("long_idle", int'(busy), 0);
        if (evt_cnt - b_evt == 2) begin
            rec = ev_log[b_evt];
            chk("long_first", int'(rec), 3'b000);
            rec = ev_log[b_evt + 1];
            chk("long_second", int'(rec), 3'b100);
            chk("long_gap", ev_cyc[b_evt + 1] - ev_cyc[b_evt], LONG_CYC);
        end

        // Backpressure
        b_evt = evt_cnt; b_drop = drop_cnt;
        ev_ready = 1'b0;
        bt = 4'b0100;
        wait_cycles(2);
        bt = 4'b0000;
        wait_cycles(10);
        bt = 4'b1000;
        wait_cycles(3);
        bt = 4'b0000;
        wait_cycles(15);
        chk("bp_valid", int'(ev_valid), 1);
        chk("bp_id", int'(ev_id), 2);
        chk("bp_drop_count", drop_cnt - b_drop, 1);
        chk("bp_no_transfer", evt_cnt - b_evt, 0);
        ev_ready = 1'b1;
        tick();
        chk("bp_drained", int'(ev_valid), 0);
        chk("bp_transfer", evt_cnt - b_evt, 1);
        wait_cycles(5);

        // Reset mid-operation
        bt = 4'b0010;
        wait_cycles(4);
        chk("rst_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        wait_cycles(2);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(ev_drop), 0);
        chk("rst_id", int'(ev_id), 0);
        chk("rst_long", int'(ev_long), 0);
        rst_n = 1'b1;
        b_evt = evt_cnt; b_busy = busy_cnt;
        wait_cycles(15);
        chk("rst_held_no_event", evt_cnt - b_evt, 0);
        chk("rst_held_no_busy", busy_cnt - b_busy, 0);
        bt = 4'b0000;
        wait_cycles(3);
        bt = 4'b0010;
        wait_cycles(3);
        bt = 4'b0000;
        wait_cycles(15);
        chk("rst_repress_count", evt_cnt - b_evt, 1);
        if (evt_cnt - b_evt == 1) begin
            rec = ev_log[b_evt];
            chk("rst_repress_id", int'(rec[1:0]), 1);
        end

        // Randomized run, checked every cycle against the model
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 7) == 0) bt[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 199) == 0) bt = 4'b0000;
            ev_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                wait_cycles($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            tick();
        end

        bt = 4'b0000;
        ev_ready = 1'b1;
        wait_cycles(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_panel_arbiter.md
# btn_panel_arbiter

Front-panel input controller for the washing-machine design. It takes N raw mechanical buttons and synchronizes them. One shared lockout/hold timer serves all buttons, and simultaneous presses are resolved by fixed priority. Results go to the main control FSM as single events (short press, long press) over a valid/ready handshake with a one-entry buffer. It replaces per-button pulse generators so the control FSM sees at most one button event at a time.

## Interface
- `N_BTN`, 4: number of buttons; index 0 has highest priority.
- `LOCK_CYC`, 25_000_000: lockout length in clk cycles after a press edge. Must be ≥ 2.
- `LONG_CYC`, 50_000_000: hold length in clk cycles for a long press. Must be > `LOCK_CYC`.
- `clk` in 1: the single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `bt` in N_BTN: raw button levels; asynchronous to clk; 1 = pressed.
- `ev_ready` in 1: consumer accepts the event this cycle.
- `ev_valid` out 1: event buffer holds an event.
- `ev_id` out $clog2(N_BTN): index of the button that produced the event.
- `ev_long` out 1: 0 = short (press) event, 1 = long-press event.
- `ev_drop` out 1: one-cycle pulse when an event is discarded because the buffer is full.
- `busy` out 1: arbiter is not in IDLE.

## Operation
- **Input conditioning**
  - Each `bt` bit passes through a 2-flop synchronizer (ff1, ff2) and a history register (prv).
  - Rising-edge vector: `rise = ff2 & ~prv`.
- **Counter**
  - Width `$clog2(LONG_CYC+1)`.
  - Cleared on entry to ACTIVE, increments every cycle, saturates at `LONG_CYC`.
- **FSM states**
  - IDLE: if `rise != 0`, capture `sel` = lowest set index of `rise`. Emit short event (`sel`, long=0). Clear counter. Go to ACTIVE.
  - ACTIVE
    - All `rise` bits are ignored, including re-edges of `sel`.
    - If counter == `LONG_CYC-1` and `ff2[sel]`==1: emit long event (`sel`, long=1) and go to HELD.
    - Else if counter ≥ `LOCK_CYC-1` and `ff2[sel]`==0: go to IDLE.
  - HELD: ignore all edges. When `ff2[sel]`==0, go to IDLE.
- **Releasing buttons**
  - A button released during lockout keeps the FSM in ACTIVE until lockout expires.
  - Other buttons still held when the FSM returns to IDLE produce no event until they are released and pressed again, because no new rising edge occurs.
- **Event buffer**
  - Single entry.
  - `ev_valid & ev_ready` empties the buffer at the clock edge.
  - If an event is emitted in the same cycle, it loads the buffer (ev_valid stays 1 with the new id).
  - If the buffer is full, not being consumed, and an event is emitted: the new event is dropped, `ev_drop`=1 for that cycle, and the buffer contents are unchanged.
- `busy` = (state != IDLE).

## Timing
- **Reset values**
  - `ev_valid`, `ev_id`, `ev_long`, `ev_drop`, `busy` = 0. State IDLE, counter 0.
  - ff1, ff2 and prv are reset to all-ones. A button held through reset therefore never yields an edge; it must be released and re-pressed.
- **Latency**
  - `bt` sampled high at edge k → ff2 high after k+1 → event registered at edge k+2.
  - `ev_valid` is high during the cycle after edge k+2.
- **Long event**: registered at the edge where the counter goes from `LONG_CYC-1` to `LONG_CYC`, i.e. `LONG_CYC` cycles after the short event.
- **Minimum ACTIVE dwell**: `LOCK_CYC` cycles.
- **Handshake**
  - `ev_id` and `ev_long` are stable while `ev_valid`=1 and `ev_ready`=0.
  - `ev_ready` may be high with `ev_valid` low; this has no effect.
- **Reset mid-operation**: asserting `rst_n`=0 in any state forces the reset values asynchronously. A pending event is lost and `ev_drop` does not pulse.

## Structure
- **Package `wm_btn_pkg`** contains:
  - the state enum (IDLE, ACTIVE, HELD);
  - default `N_BTN`, `LOCK_CYC`, `LONG_CYC`;
  - the event struct {id, long}.
- **Sub-module `btn_sync`**
  - Per-vector ff1/ff2/prv chain with async reset to ones.
  - Outputs the `ff2` level vector and the `rise` vector.
- **Top `btn_panel_arbiter`** holds the FSM, counter, priority encoder and event buffer.

## Test plan
Run all scenarios with N_BTN=4, LOCK_CYC=8, LONG_CYC=20.
- **Single press:** bt=4'b0100 for 5 cycles, ev_ready=1 → one event with ev_id=2, ev_long=0, 3 edges after press; busy high for exactly 8 cycles.
- **Bounce:** bt[1] toggles 4 times within 6 cycles, then stays low → exactly one event with ev_id=1; no second event.
- **Simultaneous press:** bt=4'b1010 held 12 cycles, then released → only ev_id=1; no event for button 3 at any point.
- **Long press:** bt[0] held 30 cycles → short event (id 0, long=0), then long event (id 0, long=1) 20 cycles later, then IDLE after release; 2 events total.
- **Backpressure:** ev_ready=0; press bt[2], wait 10 cycles, press bt[3] → ev_id stays 2, ev_drop pulses once on the button-3 event; ev_ready=1 → buffer empties.
- **Reset mid-operation:** rst_n low for 2 cycles while in ACTIVE with bt[1] held → all outputs 0; no event until bt[1] is released and re-pressed.
